// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm
//
// Traffic-signal phase controller. Cycles RED -> GREEN -> YELLOW -> RED with
// parameterised phase durations. A latched pedestrian request can end GREEN
// early, once GREEN has run for at least MIN_GREEN enabled cycles.
//
// Ports:
//   clk           - system clock, rising-edge active
//   rst_n         - asynchronous active-low reset
//   enable        - tick qualifier; phase state and counter hold while low
//   ped_req       - pedestrian request (level or pulse), sampled every clock
//   current_state - one-hot phase: 001 = RED, 100 = GREEN, 010 = YELLOW
//   phase_cnt     - enabled cycles elapsed in the current phase, from 0
//   phase_start   - one-cycle pulse in the first cycle of each new phase
//   ped_wait      - a pedestrian request is latched and not yet served

`timescale 1ns/1ps

module traffic_phase_fsm #(
    parameter int unsigned RED_CYCLES    = 8,
    parameter int unsigned GREEN_CYCLES  = 12,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned MIN_GREEN     = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             ped_req,
    output logic [2:0]       current_state,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             phase_start,
    output logic             ped_wait
);

    // The state encoding is the externally visible one-hot phase value.
    typedef enum logic [2:0] {
        StRed    = 3'b001,
        StYellow = 3'b010,
        StGreen  = 3'b100
    } state_e;

    // Terminal counter values; phase_cnt never exceeds these, so no wrap.
    localparam logic [CNT_W-1:0] RedLast      = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GreenLast    = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YellowLast   = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MinGreenLast = CNT_W'(MIN_GREEN - 1);

    // state_q is a plain vector rather than state_e so that non-one-hot
    // values can exist and be detected and recovered from.
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             wait_q, wait_d;

    logic [CNT_W-1:0] last_cnt;
    logic [2:0]       next_phase;
    logic             state_legal;
    logic             ped_exit;
    logic             phase_end;
    logic             enter_red;

    // Per-phase duration and successor decode.
    always_comb begin
        state_legal = 1'b1;
        last_cnt    = RedLast;
        next_phase  = StGreen;
        case (state_q)
            StRed: begin
                last_cnt   = RedLast;
                next_phase = StGreen;
            end
            StGreen: begin
                last_cnt   = GreenLast;
                next_phase = StYellow;
            end
            StYellow: begin
                last_cnt   = YellowLast;
                next_phase = StRed;
            end
            default: begin
                state_legal = 1'b0;
            end
        endcase
    end

    // A pending pedestrian request ends GREEN through the normal phase-end path.
    assign ped_exit  = (state_q == StGreen) && wait_q && (cnt_q >= MinGreenLast);
    assign phase_end = (cnt_q == last_cnt) || ped_exit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;

        if (!state_legal) begin
            // Recovery is unconditional: it does not wait for enable.
            state_d = StRed;
            cnt_d   = '0;
            start_d = 1'b1;
        end else if (enable) begin
            if (phase_end) begin
                state_d = next_phase;
                cnt_d   = '0;
                start_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Entering RED serves the pedestrians, so the latch clears and wins
        // over a request arriving in the same cycle.
        enter_red = (state_d == StRed) && (state_q != StRed);
        wait_d    = (wait_q | (ped_req & (state_q != StRed))) & ~enter_red;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRed;
            cnt_q   <= '0;
            start_q <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            wait_q  <= wait_d;
        end
    end

    assign current_state = state_q;
    assign phase_cnt     = cnt_q;
    assign phase_start   = start_q;
    assign ped_wait      = wait_q;

endmodule
